// File: rtl/ctrl_encoder.sv
// ctrl_encoder
//   Encodes a decoded control bundle (flags + register fields + immediate)
//   back into a 32-bit RV32 instruction word and streams the words into
//   instruction memory through a small FIFO. Each memory write advances the
//   byte address by 4 from BASE_ADDR. Bundles that match no instruction
//   class are consumed but not queued, and raise a sticky error flag.
//
// Ports
//   clk, arst_n        clock (rising edge), asynchronous active-low reset
//   start              one-cycle flush: empties FIFO, reloads address, clears errors
//   in_valid/in_ready  bundle handshake; in_ready depends only on FIFO fullness
//   alu_src..jump      control flags of the bundle
//   alu_op             2-bit ALUOp (00 add, 01 sub, 10 R-type)
//   rd, rs1, rs2       register fields
//   funct3, funct7     function fields
//   imm                21-bit immediate, sign in imm[20]
//   imem_valid/ready   memory write handshake, valid whenever FIFO non-empty
//   imem_addr          byte address of current write
//   imem_wdata         encoded word at FIFO head (0 when empty)
//   count              FIFO occupancy
//   err_illegal        sticky flag: an unencodable bundle was consumed
//   illegal_cnt        saturating count of consumed illegal bundles
//
// Build option
//   CTRL_ENC_ILLEGAL_CNT_EN  when defined, builds the illegal-bundle counter;
//                            otherwise illegal_cnt is tied to 0.

module ctrl_encoder #(
    parameter int                 DEPTH     = 4,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      alu_src,
    input  logic                      mem_2_reg,
    input  logic                      reg_write,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      branch,
    input  logic                      jump,
    input  logic [1:0]                alu_op,
    input  logic [4:0]                rd,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic [20:0]               imm,
    output logic                      imem_valid,
    input  logic                      imem_ready,
    output logic [ADDR_W-1:0]         imem_addr,
    output logic [31:0]               imem_wdata,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      err_illegal,
    output logic [7:0]                illegal_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          take;
    logic          push;
    logic          pop;
    logic          illegal;
    logic          legal;
    logic [31:0]   enc_word;

    // Priority-ordered class match; first hit wins.
    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        if (jump && reg_write && mem_2_reg) begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        end else if (branch && alu_op == 2'b01) begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        end else if (mem_read && reg_write && alu_src && mem_2_reg) begin
            enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        end else if (mem_write && alu_src) begin
            enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        end else if (reg_write && alu_src && !mem_2_reg) begin
            enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
        end else if (reg_write && !alu_src && alu_op == 2'b10) begin
            enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
        end else begin
            legal    = 1'b0;
        end
    end

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign in_ready   = !full;
    assign imem_valid = !empty;
    assign imem_wdata = empty ? 32'h0 : mem[rd_ptr];

    // start wins over both FIFO ports in the same cycle.
    assign take    = in_valid && in_ready;
    assign push    = take && legal && !start;
    assign pop     = imem_valid && imem_ready && !start;
    assign illegal = take && !legal && !start;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            imem_addr   <= BASE_ADDR;
            err_illegal <= 1'b0;
        end else if (start) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            imem_addr   <= BASE_ADDR;
            err_illegal <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                imem_addr <= imem_addr + ADDR_W'(4);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (illegal) begin
                err_illegal <= 1'b1;
            end
        end
    end

`ifdef CTRL_ENC_ILLEGAL_CNT_EN
    logic [7:0] ill_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ill_cnt_q <= '0;
        end else if (start) begin
            ill_cnt_q <= '0;
        end else if (illegal && ill_cnt_q != 8'hFF) begin
            ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    assign illegal_cnt = ill_cnt_q;
`else
    assign illegal_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ctrl_encoder.sv
// Self-checking bench for ctrl_encoder: directed scenarios plus a randomized
// run compared against a queue-based reference model.

module tb_ctrl_encoder;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump;
    logic [1:0]  alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] imm;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;
    logic        err_illegal;
    logic [7:0]  illegal_cnt;

    ctrl_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_src(alu_src), .mem_2_reg(mem_2_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_valid(imem_valid), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] m_addr;
    bit          m_err;
    int          m_icnt;

    function automatic void model_clear();
        q.delete();
        m_addr = BASE;
        m_err  = 1'b0;
        m_icnt = 0;
    endfunction

    function automatic int exp_icnt();
`ifdef CTRL_ENC_ILLEGAL_CNT_EN
        return m_icnt;
`else
        return 0;
`endif
    endfunction

    // Builds the instruction word from the field layout with shifts and masks.
    function automatic bit ref_enc(output logic [31:0] w);
        int unsigned im, op, base;
        im   = 32'(imm);
        base = (32'(rs1) << 15) | (32'(funct3) << 12);
        w    = '0;
        if (jump && reg_write && mem_2_reg) begin
            op = 32'h6F;
            w  = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                 (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) |
                 (32'(rd) << 7) | op;
        end else if (branch && alu_op == 2'd1) begin
            op = 32'h63;
            w  = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) |
                 (32'(rs2) << 20) | base | (((im >> 1) & 32'hF) << 8) |
                 (((im >> 11) & 1) << 7) | op;
        end else if (mem_read && reg_write && alu_src && mem_2_reg) begin
            w  = ((im & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'h03;
        end else if (mem_write && alu_src) begin
            w  = (((im >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base |
                 ((im & 32'h1F) << 7) | 32'h23;
        end else if (reg_write && alu_src && !mem_2_reg) begin
            w  = ((im & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'h13;
        end else if (reg_write && !alu_src && alu_op == 2'd2) begin
            w  = (32'(funct7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33;
        end else begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic compare();
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("imem_valid", imem_valid, q.size() != 0);
        chk("count", count, q.size());
        chk("err_illegal", err_illegal, m_err);
        chk("illegal_cnt", illegal_cnt, exp_icnt());
        if (q.size() != 0) begin
            chk("imem_wdata", imem_wdata, q[0]);
            chk("imem_addr", imem_addr, m_addr);
        end
    endtask

    // Inputs are driven at negedge; check, clock, update model, return at negedge.
    task automatic step();
        logic [31:0] w;
        bit          lg;
        bit          rdy;
        #1 compare();
        @(posedge clk);
        if (start) begin
            model_clear();
        end else begin
            rdy = q.size() < DEPTH;
            if (q.size() != 0 && imem_ready) begin
                void'(q.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (in_valid && rdy) begin
                lg = ref_enc(w);
                if (lg) begin
                    q.push_back(w);
                end else begin
                    m_err = 1'b1;
                    if (m_icnt < 255) m_icnt++;
                end
            end
        end
        @(negedge clk);
    endtask

    // flags = {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump}
    task automatic set_b(input logic [6:0] flags, input logic [1:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [20:0] im);
        {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump} = flags;
        alu_op = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic rand_itype();
        set_b(7'b1010000, 2'd0, 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), 21'($urandom));
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
        set_b(7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0);
        model_clear();

        #12;
        compare();
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;

        // Directed encodings
        imem_ready = 1'b1;
        set_b(7'b1010000, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd5);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("itype_valid", imem_valid, 1'b1);
        chk("itype_data", imem_wdata, 32'h00500093);
        chk("itype_addr", imem_addr, 32'h0);
        step();

        set_b(7'b0010000, 2'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("rtype_data", imem_wdata, 32'h002081B3);
        step();

        set_b(7'b0000010, 2'd1, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd8);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("btype_data", imem_wdata, 32'h00208463);
        step();

        set_b(7'b0110001, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd16);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("jtype_data", imem_wdata, 32'h010000EF);
        step();

        // Backpressure: fill, stall, then drain in order
        pulse_start();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_itype();
            in_valid = 1'b1;
            step();
            if (i == 3) begin
                chk("bp_ready", in_ready, 1'b0);
                chk("bp_count", count, 3'd4);
            end
        end
        in_valid = 1'b0;
        step(); step();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_addr", imem_addr, 32'(i * 4));
            step();
        end
        chk("bp_drained", imem_valid, 1'b0);

        // Illegal bundle and start clearing it
        set_b(7'd0, 2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 21'd0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("ill_err", err_illegal, 1'b1);
        chk("ill_valid", imem_valid, 1'b0);
`ifdef CTRL_ENC_ILLEGAL_CNT_EN
        chk("ill_cnt", illegal_cnt, 8'd1);
`else
        chk("ill_cnt", illegal_cnt, 8'd0);
`endif
        pulse_start();
        chk("ill_err_clr", err_illegal, 1'b0);
        chk("ill_cnt_clr", illegal_cnt, 8'd0);

        // Saturation of the illegal counter
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) step();
        in_valid = 1'b0;
`ifdef CTRL_ENC_ILLEGAL_CNT_EN
        chk("ill_sat", illegal_cnt, 8'd255);
`else
        chk("ill_sat", illegal_cnt, 8'd0);
`endif
        pulse_start();

        // Reset mid-stream
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_itype(); in_valid = 1'b1; step();
        end
        in_valid = 1'b0;
        step();
        arst_n = 1'b0;
        #1;
        chk("rst_mid_valid", imem_valid, 1'b0);
        chk("rst_mid_count", count, 3'd0);
        model_clear();
        @(negedge clk);
        arst_n = 1'b1;
        imem_ready = 1'b1;
        rand_itype(); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("rst_mid_addr", imem_addr, BASE);
        step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump} = 7'($urandom);
            alu_op   = 2'($urandom);
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            funct3   = 3'($urandom);
            funct7   = 7'($urandom);
            imm      = 21'($urandom);
            in_valid   = ($urandom_range(0, 9) < 7);
            imem_ready = ($urandom_range(0, 9) < 6);
            start      = ($urandom_range(0, 59) == 0);
            step();
        end
        start = 1'b0; in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_encoder.md
CTRL_ENCODER -- requirements
Module: ctrl_encoder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DEPTH, 4, FIFO entries (power of two, >=2).
- ADDR_W, 32, imem_addr width.
- BASE_ADDR, 0, first byte address written after reset or start.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; flush FIFO, reload address to BASE_ADDR.
- in_valid  in  1  control bundle valid.
- in_ready  out  1  bundle accepted when in_valid&in_ready.
- alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump  in  1 each  control bundle flags.
- alu_op  in  2  ALUOp (00 add, 01 sub, 10 R-type).
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R-type only).
- imm  in  21  immediate, sign in imm[20]; low bits used per format.
- imem_valid  out  1  write request to instruction memory.
- imem_ready  in  1  memory accepts write when imem_valid&imem_ready.
- imem_addr  out  ADDR_W  byte address of write.
- imem_wdata  out  32  encoded instruction word.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- err_illegal  out  1  sticky: an unencodable bundle was presented.
- illegal_cnt  out  8  saturating illegal-bundle count (see Configuration).

Function
REQ-003 Bundle-to-opcode mapping, evaluated in priority order:
- jump&reg_write&mem_2_reg -> 1101111, J-format.
- branch&alu_op==01 -> 1100011, B-format.
- mem_read&reg_write&alu_src&mem_2_reg -> 0000011, I-format.
- mem_write&alu_src -> 0100011, S-format.
- reg_write&alu_src&!mem_2_reg -> 0010011, I-format.
- reg_write&!alu_src&alu_op==10 -> 0110011, R-format.
- Anything else is illegal.
REQ-004 Formats:
- R: {funct7,rs2,rs1,funct3,rd,op}.
- I: {imm[11:0],rs1,funct3,rd,op}.
- S: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
- B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
- J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-005 in_ready SHALL be registered-state only (!full); no combinational path from imem_ready.
REQ-006 A legal accepted bundle SHALL be encoded and pushed in the same cycle. Earliest imem_valid is the next cycle (latency 1).
REQ-007 An illegal bundle with in_valid&in_ready SHALL be consumed, not pushed, and SHALL set err_illegal. err_illegal clears only on reset or start.
REQ-008 imem_valid = !empty. imem_wdata is the FIFO head. imem_addr and imem_wdata SHALL hold stable while imem_valid&!imem_ready.
REQ-009 Each imem handshake SHALL pop one entry and advance imem_addr by 4, wrapping modulo 2^ADDR_W.
REQ-010 Simultaneous push and pop with FIFO full is impossible (in_ready=0). With FIFO non-empty and not full, push and pop SHALL both occur and count SHALL be unchanged.
REQ-011 start SHALL override push and pop in the same cycle. Next cycle: count=0, imem_valid=0, imem_addr=BASE_ADDR, err_illegal=0, illegal_cnt=0.

Reset
REQ-012 While arst_n=0:
- FIFO empty, count=0, in_ready=1.
- imem_valid=0, imem_addr=BASE_ADDR, imem_wdata=0.
- err_illegal=0, illegal_cnt=0.
REQ-013 Asserting reset mid-transfer SHALL discard all queued entries with no partial write.

Configuration
REQ-014 Macro CTRL_ENC_ILLEGAL_CNT_EN:
- Defined: illegal_cnt increments per consumed illegal bundle and saturates at 255.
- Undefined: illegal_cnt is tied to 0 and the counter is not built.

Verification
REQ-015 Required directed scenarios:
- I-type: reg_write=1, alu_src=1, alu_op=00, rd=1, rs1=0, funct3=0, imm=5 -> one cycle later imem_wdata=0x00500093, imem_addr=0.
- R-type: reg_write=1, alu_op=10, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3. B-type: branch=1, alu_op=01, rs1=1, rs2=2, imm=8 -> 0x00208463.
- J-type: jump=1, reg_write=1, mem_2_reg=1, rd=1, imm=16 -> 0x010000EF.
- Backpressure: imem_ready=0, push 5 legal bundles -> in_ready=0 after 4 and count=4. Then imem_ready=1 -> 4 writes at addresses 0, 4, 8, 12 in order, data held stable during the stall.
- Illegal: all flags 0, in_valid=1 -> nothing written, err_illegal=1, illegal_cnt=1 (0 without the macro). start -> both clear.
- Reset mid-stream: 3 entries queued, pulse arst_n low -> imem_valid=0, count=0, next write at BASE_ADDR.
